// File: rtl/ibex_pkg.sv
// Shared Ibex types used by the PMU counter-bank arbiter.
// Holds the PMC op encoding and the arbiter state encoding.
package ibex_pkg;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2,
        PMC_WFO  = 2'd3
    } pmc_op_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } pmu_arb_state_e;

    // Wait-style ops keep being presented to the bank until the response arrives.
    function automatic logic pmc_op_is_wait(input pmc_op_e op);
        return (op == PMC_WFP) || (op == PMC_WFO);
    endfunction

endpackage

// File: rtl/ibex_pmu_rr_next.sv
// Round-robin helper: finds the first enabled index after ptr, wrapping.
// Returns ptr itself when no index is enabled.
module ibex_pmu_rr_next #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   next_idx,
    output logic               any_en
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate down so the nearest enabled one wins.
    always_comb begin
        next_idx = ptr;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (mask[idx]) begin
                next_idx = idx;
            end
        end
    end

    assign any_en = |mask;

endmodule

// File: rtl/ibex_pmu_counter_arb.sv
// Shares one PMU counter-bank port among NUM_REQ PMC requesters using a
// round-robin token; the port is held by the owner until its response returns.
module ibex_pmu_counter_arb
    import ibex_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_en_i,
    input  pmc_op_e                  req_op_i [NUM_REQ],
    input  logic [NUM_REQ-1:0][31:0] req_addr_i,
    input  logic [NUM_REQ-1:0]       req_we_i,
    input  logic [NUM_REQ-1:0][31:0] req_wdata_i,
    output logic [NUM_REQ-1:0]       req_gnt_o,
    output logic [NUM_REQ-1:0]       req_rvalid_o,
    output logic [NUM_REQ-1:0]       req_err_o,
    output logic [31:0]              req_rdata_o,
    output pmc_op_e                  pmu_op_o,
    input  logic                     pmu_gnt_i,
    input  logic                     pmu_rvalid_i,
    input  logic                     pmu_err_i,
    output logic [31:0]              pmu_addr_o,
    output logic                     pmu_we_o,
    output logic [31:0]              pmu_wdata_o,
    input  logic [31:0]              pmu_rdata_i,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         owner_o,
    output logic                     proto_err_o
);

    pmu_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    pmc_op_e          op_q, op_d;

    logic [IDX_W-1:0] next_ptr;
    logic             any_en;
    logic             offer;
    logic             accept;

    ibex_pmu_rr_next #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_next (
        .mask     (req_en_i),
        .ptr      (ptr_q),
        .next_idx (next_ptr),
        .any_en   (any_en)
    );

    // The token offer depends only on bank readiness and the enable mask, never
    // on req_op_i, so requesters may derive their op from gnt without a loop.
    assign offer  = (state_q == ARB_IDLE) && pmu_gnt_i && req_en_i[ptr_q];
    assign accept = offer && (req_op_i[ptr_q] != PMC_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            op_q    <= PMC_IDLE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op_d    = op_q;
        case (state_q)
            ARB_IDLE: begin
                // The token moves on whenever the bank is ready, whether taken or not.
                if (pmu_gnt_i && any_en) begin
                    ptr_d = next_ptr;
                end
                if (accept) begin
                    owner_d = ptr_q;
                    op_d    = req_op_i[ptr_q];
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (pmu_rvalid_i) begin
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        req_gnt_o    = '0;
        req_rvalid_o = '0;
        req_err_o    = '0;
        pmu_op_o     = PMC_IDLE;
        pmu_addr_o   = '0;
        pmu_we_o     = 1'b0;
        pmu_wdata_o  = '0;
        proto_err_o  = 1'b0;
        if (rst_ni) begin
            case (state_q)
                ARB_IDLE: begin
                    // A response with no owner is dropped and flagged.
                    proto_err_o = pmu_rvalid_i;
                    if (offer) begin
                        req_gnt_o[ptr_q] = 1'b1;
                        pmu_op_o         = req_op_i[ptr_q];
                        pmu_addr_o       = req_addr_i[ptr_q];
                        pmu_we_o         = req_we_i[ptr_q];
                        pmu_wdata_o      = req_wdata_i[ptr_q];
                    end
                end
                ARB_BUSY: begin
                    pmu_addr_o  = req_addr_i[owner_q];
                    pmu_we_o    = req_we_i[owner_q];
                    pmu_wdata_o = req_wdata_i[owner_q];
                    if (pmu_rvalid_i) begin
                        req_rvalid_o[owner_q] = 1'b1;
                        req_err_o[owner_q]    = pmu_err_i;
                    end else if (pmc_op_is_wait(op_q)) begin
                        pmu_op_o = op_q;
                    end
                end
            endcase
        end
    end

    assign req_rdata_o = rst_ni ? pmu_rdata_i : '0;
    assign busy_o      = rst_ni && (state_q == ARB_BUSY);
    assign owner_o     = rst_ni ? owner_q : '0;

endmodule

// File: tb/tb_ibex_pmu_counter_arb.sv
// Randomized scoreboard bench for ibex_pmu_counter_arb against a
// behavioural token/ownership model of the arbiter.
module tb_ibex_pmu_counter_arb;
    import ibex_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req_en = '0;
    pmc_op_e            req_op [N];
    logic [N-1:0][31:0] req_addr = '0;
    logic [N-1:0]       req_we = '0;
    logic [N-1:0][31:0] req_wdata = '0;
    logic [N-1:0]       req_gnt;
    logic [N-1:0]       req_rvalid;
    logic [N-1:0]       req_err;
    logic [31:0]        req_rdata;
    pmc_op_e            pmu_op;
    logic               pmu_gnt = 1'b0;
    logic               pmu_rvalid = 1'b0;
    logic               pmu_err = 1'b0;
    logic [31:0]        pmu_addr;
    logic               pmu_we;
    logic [31:0]        pmu_wdata;
    logic [31:0]        pmu_rdata = '0;
    logic               busy;
    logic [IW-1:0]      owner;
    logic               proto_err;

    always #5 clk = ~clk;

    ibex_pmu_counter_arb #(
        .NUM_REQ (N)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_en_i     (req_en),
        .req_op_i     (req_op),
        .req_addr_i   (req_addr),
        .req_we_i     (req_we),
        .req_wdata_i  (req_wdata),
        .req_gnt_o    (req_gnt),
        .req_rvalid_o (req_rvalid),
        .req_err_o    (req_err),
        .req_rdata_o  (req_rdata),
        .pmu_op_o     (pmu_op),
        .pmu_gnt_i    (pmu_gnt),
        .pmu_rvalid_i (pmu_rvalid),
        .pmu_err_i    (pmu_err),
        .pmu_addr_o   (pmu_addr),
        .pmu_we_o     (pmu_we),
        .pmu_wdata_o  (pmu_wdata),
        .pmu_rdata_i  (pmu_rdata),
        .busy_o       (busy),
        .owner_o      (owner),
        .proto_err_o  (proto_err)
    );

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    int    pass_cnt = 0;
    int    total_cnt = 0;
    resp_t sb_q[$];
    int    accept_log[$];

    logic [N-1:0] fixed_en;
    bit           rand_en;
    int           gnt_prob, op_prob, fixed_kind, lat_min, lat_max, spur_prob;

    bit           pend [N];
    pmc_op_e      pend_op [N];
    logic [31:0]  pend_addr [N];
    logic         pend_we [N];
    logic [31:0]  pend_wdata [N];

    bit           m_busy;
    logic [IW-1:0] m_ptr, m_owner;
    pmc_op_e      m_op;
    int           bank_wait, bank_lat;
    logic [31:0]  bank_rdata;
    bit           bank_err;
    bit           force_late = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // First enabled requester after p in circular order; p itself if none.
    function automatic logic [IW-1:0] next_enabled(input logic [IW-1:0] p, input logic [N-1:0] en);
        for (int k = 1; k <= N; k++) begin
            if (en[IW'((int'(p) + k) % N)]) return IW'((int'(p) + k) % N);
        end
        return p;
    endfunction

    task automatic setKnobs(input logic [N-1:0] en, input bit ren, input int gp, input int op,
                            input int kind, input int lmin, input int lmax, input int sp);
        fixed_en = en; rand_en = ren; gnt_prob = gp; op_prob = op;
        fixed_kind = kind; lat_min = lmin; lat_max = lmax; spur_prob = sp;
    endtask

    task automatic resetModel();
        m_busy = 1'b0; m_ptr = '0; m_owner = '0; m_op = PMC_IDLE; bank_wait = 0;
        sb_q.delete();
        accept_log.delete();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    task automatic applyStimulus();
        req_en = rand_en ? ((int'($urandom_range(0, 3)) == 0) ? N'($urandom) : {N{1'b1}}) : fixed_en;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && int'($urandom_range(0, 99)) < op_prob) begin
                pend[i]       = 1'b1;
                pend_op[i]    = (fixed_kind >= 0) ? pmc_op_e'(2'(fixed_kind)) : pmc_op_e'(2'($urandom_range(1, 3)));
                pend_addr[i]  = $urandom;
                pend_we[i]    = 1'($urandom);
                pend_wdata[i] = $urandom;
            end
            req_op[i]    = pend[i] ? pend_op[i] : PMC_IDLE;
            req_addr[i]  = pend_addr[i];
            req_we[i]    = pend_we[i];
            req_wdata[i] = pend_wdata[i];
        end
        pmu_gnt    = int'($urandom_range(0, 99)) < gnt_prob;
        pmu_rvalid = 1'b0;
        pmu_err    = 1'b0;
        pmu_rdata  = $urandom;
        if (m_busy) begin
            bank_wait++;
            if (bank_wait == bank_lat) begin
                pmu_rvalid = 1'b1;
                pmu_err    = bank_err;
                pmu_rdata  = bank_rdata;
            end
        end else if (force_late || int'($urandom_range(0, 99)) < spur_prob) begin
            pmu_rvalid = 1'b1;
            pmu_err    = 1'($urandom);
            force_late = 1'b0;
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] e_gnt;
        pmc_op_e      e_op;
        logic [31:0]  e_addr, e_wdata;
        logic         e_we, e_proto;
        bit           g;
        e_gnt = '0; e_op = PMC_IDLE; e_addr = '0; e_wdata = '0; e_we = 1'b0; e_proto = 1'b0; g = 1'b0;
        if (!m_busy) begin
            g       = pmu_gnt && req_en[m_ptr];
            e_proto = pmu_rvalid;
            if (g) begin
                e_gnt   = N'(1) << m_ptr;
                e_op    = req_op[m_ptr];
                e_addr  = req_addr[m_ptr];
                e_we    = req_we[m_ptr];
                e_wdata = req_wdata[m_ptr];
            end
        end else begin
            e_addr  = req_addr[m_owner];
            e_we    = req_we[m_owner];
            e_wdata = req_wdata[m_owner];
            if (!pmu_rvalid && m_op != PMC_REQ) e_op = m_op;
        end
        chk("gnt", 64'(req_gnt), 64'(e_gnt));
        chk("gnt_disabled", 64'(req_gnt & ~req_en), 64'(0));
        chk("pmu_op", 64'(pmu_op), 64'(e_op));
        chk("pmu_addr", 64'(pmu_addr), 64'(e_addr));
        chk("pmu_we", 64'(pmu_we), 64'(e_we));
        chk("pmu_wdata", 64'(pmu_wdata), 64'(e_wdata));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("proto_err", 64'(proto_err), 64'(e_proto));
        chk("rdata_pass", 64'(req_rdata), 64'(pmu_rdata));
        if (m_busy) chk("owner", 64'(owner), 64'(m_owner));
        if (!(m_busy && pmu_rvalid)) begin
            chk("rvalid_quiet", 64'(req_rvalid), 64'(0));
            chk("err_quiet", 64'(req_err), 64'(0));
        end
        if (!m_busy) begin
            if (g && req_op[m_ptr] != PMC_IDLE) begin
                bank_lat   = int'($urandom_range(lat_min, lat_max));
                bank_wait  = 0;
                bank_rdata = $urandom;
                bank_err   = (int'($urandom_range(0, 3)) == 0);
                sb_q.push_back('{int'(m_ptr), bank_rdata, bank_err});
                accept_log.push_back(int'(m_ptr));
                pend[m_ptr] = 1'b0;
                m_busy      = 1'b1;
                m_owner     = m_ptr;
                m_op        = req_op[m_ptr];
            end
            if (pmu_gnt) m_ptr = next_enabled(m_ptr, req_en);
        end else if (pmu_rvalid) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic step();
        applyStimulus();
        #1;
        checkOutput();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        step();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        op_prob = 0;
        spur_prob = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        while (m_busy && n < 80) begin
            nextCycle();
            n++;
        end
        if (m_busy) begin
            total_cnt++;
            $display("[TB] FAIL drain_timeout: transaction open after %0d cycles, required idle", n);
        end
        nextCycle();
    endtask

    // Monitor: every routed response must match the oldest accepted transaction.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && req_rvalid !== '0) begin
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("[TB] FAIL unexpected_rvalid: got %b, required none", req_rvalid);
                end else begin
                    r = sb_q.pop_front();
                    chk("rvalid_route", 64'(req_rvalid), 64'(1) << r.owner);
                    chk("rvalid_err", 64'(req_err), r.err ? (64'(1) << r.owner) : 64'(0));
                    chk("rvalid_rdata", 64'(req_rdata), 64'(r.rdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) req_op[i] = PMC_IDLE;

        $display("[TB] token rotation with no ops");
        setKnobs(4'hF, 1'b0, 100, 0, -1, 1, 1, 0);
        doReset();
        chk("rotate_gnt0", 64'(req_gnt), 64'(1));
        for (int c = 1; c < 5; c++) begin
            nextCycle();
            chk("rotate_gnt", 64'(req_gnt), 64'(1) << (c % 4));
        end

        $display("[TB] all requesters saturating");
        setKnobs(4'hF, 1'b0, 100, 100, 1, 1, 1, 0);
        doReset();
        for (int c = 1; c < 10; c++) nextCycle();
        chk("order_count", 64'(accept_log.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < accept_log.size()) chk("service_order", 64'(accept_log[i]), 64'(i % 4));
        end
        drain();

        $display("[TB] long WFP from requester 1");
        setKnobs(4'b0010, 1'b0, 100, 100, 2, 20, 20, 0);
        for (int c = 0; c < 26; c++) nextCycle();
        drain();

        $display("[TB] randomized traffic");
        setKnobs(4'hF, 1'b1, 80, 35, -1, 1, 6, 5);
        for (int c = 0; c < 400; c++) nextCycle();
        drain();

        $display("[TB] sparse enable mask and bank stalls");
        setKnobs(4'b0101, 1'b0, 60, 40, -1, 1, 3, 5);
        for (int c = 0; c < 60; c++) nextCycle();
        drain();
        setKnobs(4'b0101, 1'b0, 0, 100, 1, 1, 2, 0);
        for (int c = 0; c < 3; c++) nextCycle();
        gnt_prob = 100;
        for (int c = 0; c < 4; c++) nextCycle();
        drain();

        $display("[TB] reset during WFO");
        setKnobs(4'b0001, 1'b0, 100, 100, 3, 50, 50, 0);
        n = 0;
        while (!m_busy && n < 10) begin
            nextCycle();
            n++;
        end
        if (!m_busy) begin
            total_cnt++;
            $display("[TB] FAIL wfo_accept: no accept within %0d cycles, required one", n);
        end
        nextCycle();
        nextCycle();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        pmu_gnt    = 1'b1;
        pmu_rvalid = 1'b1;
        pmu_err    = 1'b1;
        pmu_rdata  = 32'hA5A5_5A5A;
        #1;
        chk("rst_gnt", 64'(req_gnt), 64'(0));
        chk("rst_rvalid", 64'(req_rvalid), 64'(0));
        chk("rst_err", 64'(req_err), 64'(0));
        chk("rst_rdata", 64'(req_rdata), 64'(0));
        chk("rst_op", 64'(pmu_op), 64'(PMC_IDLE));
        chk("rst_addr", 64'(pmu_addr), 64'(0));
        chk("rst_we", 64'(pmu_we), 64'(0));
        chk("rst_wdata", 64'(pmu_wdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_owner", 64'(owner), 64'(0));
        chk("rst_proto", 64'(proto_err), 64'(0));
        resetModel();
        force_late = 1'b1;
        op_prob = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("late_rsp_proto", 64'(proto_err), 64'(1));
        drain();

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ibex_pmu_counter_arb.md
Name: ibex_pmu_counter_arb

Overview:
Shares one PMU counter-bank port among NUM_REQ core-side PMC counter interfaces (one per hart or agent).
- Grants by a round-robin token: at most one requester holds gnt per cycle.
- Forwards the accepted op, address and data downstream, and holds the port until the response returns.
- Routes rvalid, err and rdata back to the owning requester.
- Sits between the per-core PMC counter units and the PMU counter bank.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, asynchronous, active-low
req_en_i  in  NUM_REQ  per-requester enable mask; a disabled requester never receives gnt
req_op_i  in  NUM_REQ x pmc_op_e  requester op (PMC_IDLE/PMC_REQ/PMC_WFP/PMC_WFO)
req_addr_i  in  NUM_REQ x 32  requester address
req_we_i  in  NUM_REQ  requester write enable
req_wdata_i  in  NUM_REQ x 32  requester write data
req_gnt_o  out  NUM_REQ  one-hot-or-zero token/grant
req_rvalid_o  out  NUM_REQ  response valid to owner
req_err_o  out  NUM_REQ  response error to owner
req_rdata_o  out  32  response data (broadcast; qualified by req_rvalid_o)
pmu_op_o  out  pmc_op_e  op to counter bank
pmu_gnt_i  in  1  counter bank ready; must not depend combinationally on pmu_op_o
pmu_rvalid_i  in  1  counter bank response
pmu_err_i  in  1  counter bank error (valid with pmu_rvalid_i)
pmu_addr_o  out  32  address to bank
pmu_we_o  out  1  write enable to bank
pmu_wdata_o  out  32  write data to bank
pmu_rdata_i  in  32  read data from bank
busy_o  out  1  high while a transaction is outstanding
owner_o  out  IDX_W  index of current owner (valid when busy_o)
proto_err_o  out  1  one-cycle pulse on a response while idle

Behaviour:
State and reset:
- Registers: state_q (ARB_IDLE/ARB_BUSY), ptr_q, owner_q, op_q.
- Async reset: state_q=ARB_IDLE, ptr_q=0, owner_q=0, op_q=PMC_IDLE.
- While rst_ni=0, all outputs are 0 and pmu_op_o=PMC_IDLE.

Token offer (ARB_IDLE):
- req_gnt_o[ptr_q] = pmu_gnt_i & req_en_i[ptr_q]; all other grants 0.
- req_gnt_o never depends on req_op_i, because requesters drive op combinationally from gnt (no loop).
- pmu_op/addr/we/wdata_o = requester ptr_q's signals when its grant is high; otherwise op=PMC_IDLE and addr/we/wdata=0.

Accept cycle (ARB_IDLE, grant high, req_op_i[ptr_q]!=PMC_IDLE):
- Forwards the op in the same cycle (zero added latency).
- owner_q<=ptr_q, op_q<=op, state_q<=ARB_BUSY.
- ptr_q<=next enabled index after ptr_q.

Token pass:
- Grant high but op==PMC_IDLE, or req_en_i[ptr_q]=0: ptr_q<=next enabled index after ptr_q.
- pmu_gnt_i=0: ptr_q holds.
- No enabled requester: ptr_q holds and no grant is issued.
- Worst-case token wait is NUM_REQ-1 idle-port cycles.

ARB_BUSY:
- All grants 0. addr/we/wdata muxed from owner_q.
- pmu_op_o = op_q for PMC_WFP/PMC_WFO, PMC_IDLE for PMC_REQ.
- On pmu_rvalid_i: req_rvalid_o[owner_q]=1 and req_err_o[owner_q]=pmu_err_i in the same cycle; pmu_op_o=PMC_IDLE; state_q<=ARB_IDLE.
- The next token is offered the cycle after rvalid, never in it.

Response rules:
- The counter bank responds no earlier than the cycle after accept.
- pmu_rvalid_i in ARB_IDLE (including accept cycle) is dropped and pulses proto_err_o.
- req_rdata_o = pmu_rdata_i, combinational.

Enable mask and reset:
- req_en_i deasserted for the owner during ARB_BUSY does not abort; the response is still routed.
- Reset mid-transaction abandons it; a late response is handled as a response while idle.

Next-index function: first i in ptr+1..ptr+NUM_REQ (mod NUM_REQ) with req_en_i[i]=1, wrapping; returns ptr when none is enabled.

Decomposition:
- pmc_op_e already lives in ibex_pkg.
- Add pmu_arb_state_e {ARB_IDLE, ARB_BUSY} to ibex_pkg.
- One sub-module: ibex_pmu_rr_next (combinational next-enabled-index finder: mask, current ptr -> next index, any-enabled flag).

Test Plan:
- Reset, en=4'b1111, pmu_gnt_i=1, no ops -> gnt rotates 0001,0010,0100,1000,0001 on successive cycles; pmu_op_o=PMC_IDLE throughout.
- Req2 drives PMC_REQ, we=0, addr=0x10 when granted; bank rvalid 3 cycles later with rdata=0xDEADBEEF -> pmu_addr_o=0x10 in accept cycle; busy_o=1, owner_o=2, gnt=0 during wait; req_rvalid_o=4'b0100, req_rdata_o=0xDEADBEEF; next grant goes to req3 the cycle after.
- Req1 issues PMC_WFP; bank rvalid after 20 cycles -> pmu_op_o=PMC_WFP for 20 cycles, PMC_IDLE in rvalid cycle; req_rvalid_o[1]=1.
- All four requesters hold PMC_REQ continuously, bank 1-cycle response -> service order 0,1,2,3,0; none starved.
- en=4'b0101; pmu_gnt_i toggled low for 3 cycles -> only reqs 0/2 granted; ptr_q frozen while pmu_gnt_i=0.
- pmu_rvalid_i in idle -> proto_err_o one pulse, no req_rvalid_o. Reset asserted mid-WFO -> outputs 0 immediately, state ARB_IDLE.
